// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multicycle ALU: function codes, FSM states, default widths.
package alu_multicycle_pkg;

  localparam int unsigned ALU_DATA_WIDTH  = 32;
  localparam int unsigned ALU_FUNCT_WIDTH = 6;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_MUL = 6'h24;
  localparam logic [5:0] FN_DIV = 6'h26;
  localparam logic [5:0] FN_SLL = 6'h28;
  localparam logic [5:0] FN_SRL = 6'h30;
  localparam logic [5:0] FN_AND = 6'h32;
  localparam logic [5:0] FN_OR  = 6'h34;
  localparam logic [5:0] FN_NOR = 6'h36;
  localparam logic [5:0] FN_SLT = 6'h38;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per step.
// Registers are shared: x = accumulator/remainder, y = multiplicand/quotient, z = multiplier/divisor.
module alu_iter_muldiv
  import alu_multicycle_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  div_mode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  step,
  output logic [DATA_WIDTH-1:0] res_c,
  output logic                  last_c
);

  localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

  logic                  div_q;
  logic [DATA_WIDTH-1:0] x_q, y_q, z_q;
  logic [DATA_WIDTH-1:0] x_n, y_n, z_n;
  logic [DATA_WIDTH:0]   rem_sh, diff;
  logic [CW-1:0]         cnt_q;

  // One iteration; the remainder always stays below the divisor, so W bits suffice.
  always_comb begin
    rem_sh = {x_q, y_q[DATA_WIDTH-1]};
    diff   = rem_sh - {1'b0, z_q};
    x_n    = x_q;
    y_n    = y_q;
    z_n    = z_q;
    if (div_q) begin
      if (diff[DATA_WIDTH]) begin
        x_n = rem_sh[DATA_WIDTH-1:0];
        y_n = {y_q[DATA_WIDTH-2:0], 1'b0};
      end else begin
        x_n = diff[DATA_WIDTH-1:0];
        y_n = {y_q[DATA_WIDTH-2:0], 1'b1};
      end
    end else begin
      x_n = z_q[0] ? (x_q + y_q) : x_q;
      y_n = y_q << 1;
      z_n = z_q >> 1;
    end
  end

  assign res_c  = div_q ? y_n : x_n;
  assign last_c = (cnt_q == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      cnt_q <= '0;
    end else if (start) begin
      div_q <= div_mode;
      x_q   <= '0;
      y_q   <= a;
      z_q   <= b;
      cnt_q <= '0;
    end else if (step) begin
      x_q   <= x_n;
      y_q   <= y_n;
      z_q   <= z_n;
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU with valid/ready handshakes; single-cycle ops finish on acceptance,
// mul/div iterate DATA_WIDTH cycles in alu_iter_muldiv.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = ALU_DATA_WIDTH,
  parameter int unsigned FUNCT_WIDTH = ALU_FUNCT_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  op1,
  input  logic [DATA_WIDTH-1:0]  op2,
  input  logic [FUNCT_WIDTH-1:0] funct,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   zero,
  output logic                   err
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] alu_res, res_d, md_res_c;
  logic                  alu_err, err_d, is_mul, is_div;
  logic                  md_start, md_div, md_step, md_last_c, load;

  // Single-cycle datapath and mul/div classification of the incoming request.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    case (funct)
      FUNCT_WIDTH'(FN_ADD): alu_res = op1 + op2;
      FUNCT_WIDTH'(FN_SUB): alu_res = op1 - op2;
      FUNCT_WIDTH'(FN_MUL): is_mul = 1'b1;
      FUNCT_WIDTH'(FN_DIV): begin
        if (op2 == '0) begin
          alu_res = '1;
          alu_err = 1'b1;
        end else begin
          is_div = 1'b1;
        end
      end
      FUNCT_WIDTH'(FN_SLL): alu_res = (op2 >= DATA_WIDTH'(DATA_WIDTH)) ? '0 : (op1 << op2[SHW-1:0]);
      FUNCT_WIDTH'(FN_SRL): alu_res = (op2 >= DATA_WIDTH'(DATA_WIDTH)) ? '0 : (op1 >> op2[SHW-1:0]);
      FUNCT_WIDTH'(FN_AND): alu_res = op1 & op2;
      FUNCT_WIDTH'(FN_OR):  alu_res = op1 | op2;
      FUNCT_WIDTH'(FN_NOR): alu_res = ~(op1 | op2);
      FUNCT_WIDTH'(FN_SLT): alu_res = DATA_WIDTH'(op1 < op2);
      default:              alu_err = 1'b1;
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    md_start = 1'b0;
    md_div   = 1'b0;
    md_step  = 1'b0;
    load     = 1'b0;
    res_d    = '0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_mul) begin
            md_start = 1'b1;
            state_d  = ST_MUL;
          end else if (is_div) begin
            md_start = 1'b1;
            md_div   = 1'b1;
            state_d  = ST_DIV;
          end else begin
            load    = 1'b1;
            res_d   = alu_res;
            err_d   = alu_err;
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        md_step = 1'b1;
        if (md_last_c) begin
          load    = 1'b1;
          res_d   = md_res_c;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == ST_IDLE);
      out_valid <= (state_d == ST_DONE);
      if (load) begin
        result <= res_d;
        zero   <= (res_d == '0);
        err    <= err_d;
      end
    end
  end

  alu_iter_muldiv #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_muldiv (
    .clk     (CLK),
    .rst     (RST),
    .start   (md_start),
    .div_mode(md_div),
    .a       (op1),
    .b       (op2),
    .step    (md_step),
    .res_c   (md_res_c),
    .last_c  (md_last_c)
  );

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at DATA_WIDTH=32 and 16 sharing one stimulus/monitor path.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, sel;
  logic [5:0]  funct;
  logic [31:0] a32, b32, r32;
  logic [15:0] a16, b16, r16;
  logic        iv32, ir32, ov32, z32, e32;
  logic        iv16, ir16, ov16, z16, e16;
  logic        ir_m, ov_m, z_m, e_m;
  logic [63:0] res_m;

  typedef struct {
    logic [63:0] res;
    logic        err;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_ov = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // sel=0 steers the shared stimulus/monitor to the 32-bit instance, sel=1 to the 16-bit one.
  assign iv32  = in_valid & ~sel;
  assign iv16  = in_valid & sel;
  assign ir_m  = sel ? ir16 : ir32;
  assign ov_m  = sel ? ov16 : ov32;
  assign z_m   = sel ? z16 : z32;
  assign e_m   = sel ? e16 : e32;
  assign res_m = sel ? 64'(r16) : 64'(r32);

  alu_multicycle #(.DATA_WIDTH(32), .FUNCT_WIDTH(6)) dut32 (
    .CLK(clk), .RST(rst), .in_valid(iv32), .in_ready(ir32), .op1(a32), .op2(b32),
    .funct(funct), .out_valid(ov32), .out_ready(out_ready), .result(r32), .zero(z32), .err(e32)
  );

  alu_multicycle #(.DATA_WIDTH(16), .FUNCT_WIDTH(6)) dut16 (
    .CLK(clk), .RST(rst), .in_valid(iv16), .in_ready(ir16), .op1(a16), .op2(b16),
    .funct(funct), .out_valid(ov16), .out_ready(out_ready), .result(r16), .zero(z16), .err(e16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pop on each out_valid rise, then require stable outputs while held.
  always @(negedge clk) begin
    if (!rst) begin
      if (ov_m && !prev_ov) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          cur = q.pop_front();
          check("latency", 64'(cyc), 64'(cur.due));
          check("result", res_m, cur.res);
          check("zero", 64'(z_m), 64'(cur.res == 64'd0));
          check("err", 64'(e_m), 64'(cur.err));
        end
      end else if (ov_m) begin
        check("hold_result", res_m, cur.res);
        check("hold_zero", 64'(z_m), 64'(cur.res == 64'd0));
        check("hold_err", 64'(e_m), 64'(cur.err));
      end
      if (ov_m || q.size() != 0) check("in_ready_busy", 64'(ir_m), 64'd0);
    end
    prev_ov <= ov_m;
  end

  task automatic issue(input logic [5:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] er, input logic ee, input int lat, input bit push);
    bit ok = 1'b0;
    @(negedge clk);
    funct = f;
    a32 = a[31:0];
    b32 = b[31:0];
    a16 = a[15:0];
    b16 = b[15:0];
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (ir_m) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a32 = $urandom;
    b32 = $urandom;
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    if (push) q.push_back('{er, ee, cyc + lat - 1});
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !ov_m) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_done", 64'(ok), 64'd1);
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ov_m) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_valid", 64'(ok), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    sel = 1'b0;
    funct = '0;
    a32 = '0; b32 = '0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready32", 64'(ir32), 64'd1);
    check("rst_out_valid32", 64'(ov32), 64'd0);
    check("rst_result32", 64'(r32), 64'd0);
    check("rst_zero32", 64'(z32), 64'd1);
    check("rst_err32", 64'(e32), 64'd0);
    check("rst_in_ready16", 64'(ir16), 64'd1);
    check("rst_result16", 64'(r16), 64'd0);
    check("rst_zero16", 64'(z16), 64'd1);

    // 32-bit vectors
    issue(6'h20, 64'hFFFFFFFF, 64'h1,        64'h0,        1'b0, 1,  1'b1);
    issue(6'h24, 64'h00010000, 64'h00010003, 64'h00030000, 1'b0, 33, 1'b1);
    issue(6'h26, 64'd100,      64'd7,        64'd14,       1'b0, 33, 1'b1);
    issue(6'h26, 64'd5,        64'd0,        64'hFFFFFFFF, 1'b1, 1,  1'b1);
    issue(6'h28, 64'h1,        64'd32,       64'h0,        1'b0, 1,  1'b1);
    issue(6'h30, 64'h80000000, 64'd31,       64'h1,        1'b0, 1,  1'b1);
    issue(6'h38, 64'hFFFFFFFF, 64'h1,        64'h0,        1'b0, 1,  1'b1);
    issue(6'h3F, 64'h12345678, 64'h9,        64'h0,        1'b1, 1,  1'b1);
    issue(6'h22, 64'd3,        64'd5,        64'hFFFFFFFE, 1'b0, 1,  1'b1);
    issue(6'h36, 64'hF0F0F0F0, 64'h0F0F0000, 64'h00000F0F, 1'b0, 1,  1'b1);
    issue(6'h32, 64'hF0F0F0F0, 64'h0FF00FF0, 64'h00F000F0, 1'b0, 1,  1'b1);
    issue(6'h34, 64'hF0000000, 64'h0000000F, 64'hF000000F, 1'b0, 1,  1'b1);
    issue(6'h38, 64'd1,        64'd2,        64'd1,        1'b0, 1,  1'b1);
    issue(6'h24, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h1,        1'b0, 33, 1'b1);
    issue(6'h26, 64'hFFFFFFFF, 64'd1,        64'hFFFFFFFF, 1'b0, 33, 1'b1);
    issue(6'h26, 64'd7,        64'd100,      64'd0,        1'b0, 33, 1'b1);
    drain();

    // Back-pressure: result held in DONE for 5 cycles with in_ready low
    out_ready = 1'b0;
    issue(6'h20, 64'd2, 64'd3, 64'd5, 1'b0, 1, 1'b1);
    wait_valid();
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    drain();

    // Reset in the middle of a multiply: no result ever appears
    issue(6'h24, 64'd3, 64'd4, 64'd12, 1'b0, 33, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 64'(ir32), 64'd1);
    check("abort_out_valid", 64'(ov32), 64'd0);
    check("abort_result", 64'(r32), 64'd0);
    check("abort_zero", 64'(z32), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ov32) seen = 1'b1;
    end
    check("abort_no_valid", 64'(seen), 64'd0);

    // 16-bit vectors
    @(posedge clk);
    #1 sel = 1'b1;
    issue(6'h20, 64'hFFFF, 64'h1,    64'h0,    1'b0, 1,  1'b1);
    issue(6'h24, 64'h0100, 64'h0103, 64'h0300, 1'b0, 17, 1'b1);
    issue(6'h26, 64'd100,  64'd7,    64'd14,   1'b0, 17, 1'b1);
    issue(6'h26, 64'd5,    64'd0,    64'hFFFF, 1'b1, 1,  1'b1);
    issue(6'h28, 64'h1,    64'd16,   64'h0,    1'b0, 1,  1'b1);
    issue(6'h30, 64'h8000, 64'd15,   64'h1,    1'b0, 1,  1'b1);
    issue(6'h38, 64'hFFFF, 64'h1,    64'h0,    1'b0, 1,  1'b1);
    issue(6'h3F, 64'h1234, 64'h9,    64'h0,    1'b1, 1,  1'b1);
    issue(6'h22, 64'd3,    64'd5,    64'hFFFE, 1'b0, 1,  1'b1);
    issue(6'h24, 64'h00FF, 64'h0101, 64'hFFFF, 1'b0, 17, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
